// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5,
        StTrap      = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        WbAlu = 2'd0,
        WbRam = 2'd1,
        WbPc4 = 2'd2,
        WbImm = 2'd3
    } wb_sel_t;

    typedef enum logic [2:0] {
        ClsOp     = 3'd0,
        ClsOpImm  = 3'd1,
        ClsLoad   = 3'd2,
        ClsStore  = 3'd3,
        ClsBranch = 3'd4,
        ClsJal    = 3'd5,
        ClsLui    = 3'd6
    } instr_class_t;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcLui    = 7'b0110111;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Srl    = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Word   = 3'b010;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // Map an OP/OP-IMM funct3 to the ALU operation; alt selects SUB/SRA.
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3AddSub: op = alt ? AluSub : AluAdd;
            F3Sll:    op = AluSll;
            F3Slt:    op = AluSlt;
            F3Sltu:   op = AluSltu;
            F3Xor:    op = AluXor;
            F3Srl:    op = alt ? AluSra : AluSrl;
            F3Or:     op = AluOr;
            default:  op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_instr_decoder.sv
// Combinational RV32I subset decoder: classifies the instruction and picks ALU/writeback selects.
module riscv_instr_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] cls,
    output logic [3:0] alu_op,
    output logic       alu_b_sel,
    output logic [1:0] wb_sel,
    output logic       illegal
);

    // Decode opcode/funct fields; anything outside the supported set flags illegal.
    always_comb begin
        cls       = ClsOp;
        alu_op    = AluAdd;
        alu_b_sel = 1'b0;
        wb_sel    = WbAlu;
        illegal   = 1'b0;
        case (opcode)
            OpcOp: begin
                alu_op = alu_from_f3(funct3, funct7[5]);
                if (funct7 == F7Alt) begin
                    illegal = !((funct3 == F3AddSub) || (funct3 == F3Srl));
                end else begin
                    illegal = (funct7 != F7Base);
                end
            end
            OpcOpImm: begin
                cls       = ClsOpImm;
                alu_b_sel = 1'b1;
                // funct7 is only an opcode extension for shifts; elsewhere it is immediate.
                alu_op    = alu_from_f3(funct3, (funct3 == F3Srl) && funct7[5]);
                if (funct3 == F3Sll) begin
                    illegal = (funct7 != F7Base);
                end else if (funct3 == F3Srl) begin
                    illegal = (funct7 != F7Base) && (funct7 != F7Alt);
                end
            end
            OpcLoad: begin
                cls       = ClsLoad;
                alu_b_sel = 1'b1;
                wb_sel    = WbRam;
                illegal   = (funct3 != F3Word);
            end
            OpcStore: begin
                cls       = ClsStore;
                alu_b_sel = 1'b1;
                illegal   = (funct3 != F3Word);
            end
            OpcBranch: begin
                cls     = ClsBranch;
                alu_op  = funct3[2] ? AluSlt : AluSub;
                // Only BEQ/BNE/BLT/BGE: funct3[1] set means BLTU/BGEU or reserved.
                illegal = funct3[1];
            end
            OpcJal: begin
                cls    = ClsJal;
                wb_sel = WbPc4;
            end
            OpcLui: begin
                cls    = ClsLui;
                wb_sel = WbImm;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback with bus timeout traps.
module riscv_mc_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        rom_ready,
    input  logic        ram_ready,
    input  logic        alu_zero,
    output logic        rom_read,
    output logic        ir_en,
    output logic        ram_read,
    output logic        ram_write,
    output logic        rb_wren,
    output logic [3:0]  alu_op,
    output logic        alu_b_sel,
    output logic [1:0]  wb_sel,
    output logic        pc_en,
    output logic        pc_sel,
    output logic        instr_retired,
    output logic        illegal,
    output logic        bus_error
);

    // Last counter value at which a held strobe may still be answered.
    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(MAX_WAIT - 1);

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              illegal_q;
    logic              bus_error_q;
    instr_class_t      cls_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    alu_op_t           alu_op_q;
    logic              alu_b_sel_q;
    wb_sel_t           wb_sel_q;

    logic [2:0] dec_cls;
    logic [3:0] dec_alu_op;
    logic       dec_alu_b_sel;
    logic [1:0] dec_wb_sel;
    logic       dec_illegal;
    logic       wait_expired;
    logic       branch_taken;
    logic       unused_bits;

    riscv_instr_decoder u_decoder (
        .opcode    (instr[6:0]),
        .funct3    (instr[14:12]),
        .funct7    (instr[31:25]),
        .cls       (dec_cls),
        .alu_op    (dec_alu_op),
        .alu_b_sel (dec_alu_b_sel),
        .wb_sel    (dec_wb_sel),
        .illegal   (dec_illegal)
    );

    assign wait_expired = (wait_q == WaitLast);
    // BEQ/BGE take on zero, BNE/BLT on non-zero.
    assign branch_taken = alu_zero ^ (funct3_q[0] ^ funct3_q[2]);
    assign unused_bits  = ^{instr[24:15], funct3_q[1]};
    assign illegal      = illegal_q;
    assign bus_error    = bus_error_q;

    // State register, wait counter, sticky traps and decode fields latched in DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            cls_q       <= ClsOp;
            funct3_q    <= '0;
            rd_q        <= '0;
            alu_op_q    <= AluAdd;
            alu_b_sel_q <= 1'b0;
            wb_sel_q    <= WbAlu;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    wait_q  <= '0;
                end
                StFetch: begin
                    if (rom_ready) begin
                        state_q <= StDecode;
                    end else if (wait_expired) begin
                        state_q     <= StTrap;
                        bus_error_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StDecode: begin
                    cls_q       <= instr_class_t'(dec_cls);
                    funct3_q    <= instr[14:12];
                    rd_q        <= instr[11:7];
                    alu_op_q    <= alu_op_t'(dec_alu_op);
                    alu_b_sel_q <= dec_alu_b_sel;
                    wb_sel_q    <= wb_sel_t'(dec_wb_sel);
                    if (dec_illegal) begin
                        state_q   <= StTrap;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= StExecute;
                    end
                end
                StExecute: begin
                    wait_q <= '0;
                    if (cls_q == ClsBranch) begin
                        state_q <= StFetch;
                    end else if ((cls_q == ClsLoad) || (cls_q == ClsStore)) begin
                        state_q <= StMem;
                    end else begin
                        state_q <= StWriteback;
                    end
                end
                StMem: begin
                    if (ram_ready) begin
                        state_q <= (cls_q == ClsLoad) ? StWriteback : StFetch;
                        wait_q  <= '0;
                    end else if (wait_expired) begin
                        state_q     <= StTrap;
                        bus_error_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StWriteback: begin
                    state_q <= StFetch;
                    wait_q  <= '0;
                end
                StTrap:  state_q <= StTrap;
                default: state_q <= StTrap;
            endcase
        end
    end

    // Datapath controls from state and latched fields; held low during reset so an
    // aborted instruction never commits a register or PC write.
    always_comb begin
        rom_read      = 1'b0;
        ir_en         = 1'b0;
        ram_read      = 1'b0;
        ram_write     = 1'b0;
        rb_wren       = 1'b0;
        alu_op        = AluAdd;
        alu_b_sel     = 1'b0;
        wb_sel        = WbAlu;
        pc_en         = 1'b0;
        pc_sel        = 1'b0;
        instr_retired = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    rom_read = 1'b1;
                    ir_en    = rom_ready;
                end
                StExecute: begin
                    alu_op    = alu_op_q;
                    alu_b_sel = alu_b_sel_q;
                    if (cls_q == ClsBranch) begin
                        pc_en         = 1'b1;
                        pc_sel        = branch_taken;
                        instr_retired = 1'b1;
                    end
                end
                StMem: begin
                    // Keep the address computation stable while the RAM is busy.
                    alu_op    = alu_op_q;
                    alu_b_sel = alu_b_sel_q;
                    if (cls_q == ClsLoad) begin
                        ram_read = 1'b1;
                    end else begin
                        ram_write     = 1'b1;
                        pc_en         = ram_ready;
                        instr_retired = ram_ready;
                    end
                end
                StWriteback: begin
                    alu_op        = alu_op_q;
                    alu_b_sel     = alu_b_sel_q;
                    rb_wren       = (rd_q != 5'd0);
                    wb_sel        = wb_sel_q;
                    pc_en         = 1'b1;
                    pc_sel        = (cls_q == ClsJal);
                    instr_retired = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
